snake_score: RTL and testbench
==============================

SNAKE_SCORE -- requirements
Module: snake_score

Interface
REQ-001 The block SHALL have parameter MAX_SCORE, default 99, the terminal score (legal range 1..99, BCD-counted).
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: a one-cycle pulse that begins or restarts a game.
REQ-005 The block SHALL have port eat, input, 1 bit: level from the game logic; each rising edge is one food eaten.
REQ-006 The block SHALL have port game_over, input, 1 bit: a one-cycle pulse that ends the game.
REQ-007 The block SHALL have port score_data, output, 4 bits: the BCD ones digit of the current score, which drives the one-digit display stage.
REQ-008 The block SHALL have port score_tens, output, 4 bits: the BCD tens digit of the current score.
REQ-009 The block SHALL have port hi_ones and hi_tens, outputs, 4 bits each: the BCD high score.
REQ-010 The block SHALL have port score_vld, output, 1 bit: a one-cycle pulse in the cycle after any score change.
REQ-011 The block SHALL have port game_st, output, 2 bits: the current state encoding.
REQ-012 The block SHALL have port win, output, 1 bit: high while the game ended by reaching MAX_SCORE.

Function
REQ-013 The FSM SHALL have states IDLE=0, PLAY=1 and OVER=2; encoding 3 SHALL be unreachable and SHALL recover to IDLE on the next clock.
REQ-014 IDLE and OVER: on start, the block SHALL go to PLAY, clear the score to 00, clear win and pulse score_vld.
REQ-015 PLAY: eat edge detection SHALL be eat & ~eat_q, where eat_q is eat registered once; the score SHALL increment by 1 on the same edge, so the new value is visible one cycle after eat rises.
REQ-016 The increment SHALL be BCD: the ones digit wraps 9->0 and carries into tens; score_data and score_tens SHALL never exceed 9.
REQ-017 If an increment reaches MAX_SCORE, the score SHALL hold at MAX_SCORE, win SHALL set and the state SHALL go to OVER on the same edge.
REQ-018 PLAY with game_over: the state SHALL go to OVER and the score SHALL freeze.
REQ-019 Priority in one cycle SHALL be start > game_over > eat edge; game_over together with an eat edge SHALL count the food, then go to OVER.
REQ-020 start while in PLAY SHALL restart the game: the score clears to 00 and the state stays PLAY.
REQ-021 In IDLE and OVER, eat edges SHALL be ignored; eat_q SHALL still track eat, so a level already high when PLAY is entered does not count.
REQ-022 On the edge entering OVER, if score > {hi_tens, hi_ones}, the high score SHALL be loaded with the final score; otherwise it is unchanged.

Reset
REQ-023 While rst is high, the block SHALL hold state IDLE, the score 00, the high score 00, eat_q=0, score_vld=0 and win=0.
REQ-024 Reset asserted mid-game SHALL abort immediately, and the high score SHALL be lost.
REQ-025 After rst falls, the block SHALL stay in IDLE until start.

Configuration
REQ-026 With SNAKE_SCORE_HISCORE_EN defined, the high-score registers and the REQ-022 compare SHALL be present.
REQ-027 Without SNAKE_SCORE_HISCORE_EN, hi_ones and hi_tens SHALL be tied to 0, no high-score flops SHALL exist, and all other behaviour SHALL be identical.

Structure
REQ-028 Package snake_pkg SHALL hold the state encodings, the 4-bit BCD digit type and the BCD_MAX=9 constant.
REQ-029 A combinational sub-module snake_bcd_inc SHALL take a two-digit BCD value and output value+1 plus a carry-out flag; the main FSM SHALL instantiate it.

Verification
REQ-030 Reset, start, then 12 eat rising edges, one cycle high and two low each -> score_tens=1, score_data=2, 12 score_vld pulses, game_st=1.
REQ-031 Score 09, then one eat edge -> score_tens=1 and score_data=0 one cycle after the edge, with exactly one score_vld pulse.
REQ-032 MAX_SCORE=15, 15 eat edges -> score=15, win=1, game_st=2; a 16th edge leaves the score at 15 with no score_vld pulse.
REQ-033 Game 1 ends at 07 via game_over, then start and game 2 ends at 04 -> hi stays 07; game 3 ends at 11 -> hi=11. Without the macro, hi stays 00.
REQ-034 game_over and an eat edge in the same cycle at score 03 -> final score 04, game_st=2; start and game_over in the same cycle -> PLAY with score 00.
REQ-035 rst pulsed at score 05 with hi=08 -> all outputs 0 and game_st=0; eat held high through start -> no count until eat falls and rises again.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types for the snake score block: FSM state encodings and the BCD digit type.
package snake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

endpackage

// File: rtl/snake_bcd_inc.sv
// Two-digit BCD incrementer; carry_o flags the 99 -> 00 wrap.
module snake_bcd_inc
  import snake_pkg::*;
(
  input  bcd_t tens_i,
  input  bcd_t ones_i,
  output bcd_t tens_o,
  output bcd_t ones_o,
  output logic carry_o
);

  always_comb begin
    tens_o  = tens_i;
    ones_o  = ones_i + 4'd1;
    carry_o = 1'b0;
    if (ones_i >= BCD_MAX) begin
      ones_o = 4'd0;
      if (tens_i >= BCD_MAX) begin
        tens_o  = 4'd0;
        carry_o = 1'b1;
      end else begin
        tens_o = tens_i + 4'd1;
      end
    end
  end

endmodule

// File: rtl/snake_score.sv
// Snake game score keeper: BCD score, win detection and optional high score.
// Define SNAKE_SCORE_HISCORE_EN to build the high-score registers.
module snake_score
  import snake_pkg::*;
#(
  parameter int MAX_SCORE = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       eat,
  input  logic       game_over,
  output logic [3:0] score_data,
  output logic [3:0] score_tens,
  output logic [3:0] hi_ones,
  output logic [3:0] hi_tens,
  output logic       score_vld,
  output logic [1:0] game_st,
  output logic       win
);

  localparam bcd_t MAX_TENS = bcd_t'(MAX_SCORE / 10);
  localparam bcd_t MAX_ONES = bcd_t'(MAX_SCORE % 10);

  state_t state_q, state_d;
  bcd_t   ones_q, ones_d;
  bcd_t   tens_q, tens_d;
  logic   vld_q, vld_d;
  logic   win_q, win_d;
  logic   eat_q;
  logic   eat_rise;
  logic   enter_over;

  bcd_t   inc_tens, inc_ones;
  logic   inc_carry;

  snake_bcd_inc u_bcd_inc (
    .tens_i  (tens_q),
    .ones_i  (ones_q),
    .tens_o  (inc_tens),
    .ones_o  (inc_ones),
    .carry_o (inc_carry)
  );

  assign eat_rise = eat & ~eat_q;

  always_comb begin
    state_d    = state_q;
    ones_d     = ones_q;
    tens_d     = tens_q;
    vld_d      = 1'b0;
    win_d      = win_q;
    enter_over = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d = ST_PLAY;
          ones_d  = 4'd0;
          tens_d  = 4'd0;
          win_d   = 1'b0;
          vld_d   = 1'b1;
        end
      end
      ST_PLAY: begin
        if (start) begin
          ones_d = 4'd0;
          tens_d = 4'd0;
          win_d  = 1'b0;
          vld_d  = 1'b1;
        end else begin
          // A food eaten alongside game_over still counts before the game ends.
          if (eat_rise) begin
            ones_d = inc_ones;
            tens_d = inc_tens;
            vld_d  = 1'b1;
            if (inc_carry) begin
              ones_d     = BCD_MAX;
              tens_d     = BCD_MAX;
              win_d      = 1'b1;
              enter_over = 1'b1;
            end else if (inc_tens == MAX_TENS && inc_ones == MAX_ONES) begin
              win_d      = 1'b1;
              enter_over = 1'b1;
            end
          end
          if (game_over) begin
            enter_over = 1'b1;
          end
          if (enter_over) begin
            state_d = ST_OVER;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ones_q  <= 4'd0;
      tens_q  <= 4'd0;
      vld_q   <= 1'b0;
      win_q   <= 1'b0;
      eat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      vld_q   <= vld_d;
      win_q   <= win_d;
      eat_q   <= eat;
    end
  end

`ifdef SNAKE_SCORE_HISCORE_EN
  bcd_t hi_ones_q, hi_ones_d;
  bcd_t hi_tens_q, hi_tens_d;

  // BCD digits compare correctly as a plain 8-bit unsigned value.
  always_comb begin
    hi_ones_d = hi_ones_q;
    hi_tens_d = hi_tens_q;
    if (enter_over && ({tens_d, ones_d} > {hi_tens_q, hi_ones_q})) begin
      hi_ones_d = ones_d;
      hi_tens_d = tens_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_ones_q <= 4'd0;
      hi_tens_q <= 4'd0;
    end else begin
      hi_ones_q <= hi_ones_d;
      hi_tens_q <= hi_tens_d;
    end
  end

  assign hi_ones = hi_ones_q;
  assign hi_tens = hi_tens_q;
`else
  assign hi_ones = 4'd0;
  assign hi_tens = 4'd0;
`endif

  assign score_data = ones_q;
  assign score_tens = tens_q;
  assign score_vld  = vld_q;
  assign game_st    = state_q;
  assign win        = win_q;

endmodule

// File: tb/tb_snake_score.sv
// Self-checking bench for snake_score: directed scenarios plus random play against an integer model.
module tb_snake_score;

`ifdef SNAKE_SCORE_HISCORE_EN
  localparam int HI_EN = 1;
`else
  localparam int HI_EN = 0;
`endif

  logic clk = 1'b0;
  logic rst, start, eat, game_over;

  logic [3:0] a_ones, a_tens, a_hio, a_hit, b_ones, b_tens, b_hio, b_hit;
  logic [1:0] a_st, b_st;
  logic       a_vld, a_win, b_vld, b_win;

  snake_score #(.MAX_SCORE(99)) dut_a (
    .clk(clk), .rst(rst), .start(start), .eat(eat), .game_over(game_over),
    .score_data(a_ones), .score_tens(a_tens), .hi_ones(a_hio), .hi_tens(a_hit),
    .score_vld(a_vld), .game_st(a_st), .win(a_win)
  );

  snake_score #(.MAX_SCORE(15)) dut_b (
    .clk(clk), .rst(rst), .start(start), .eat(eat), .game_over(game_over),
    .score_data(b_ones), .score_tens(b_tens), .hi_ones(b_hio), .hi_tens(b_hit),
    .score_vld(b_vld), .game_st(b_st), .win(b_win)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  // Reference model: plain integers, index 0 = MAX 99 instance, 1 = MAX 15 instance.
  int m_max[2] = '{99, 15};
  int m_sc[2], m_st[2], m_win[2], m_hi[2], m_vld[2];
  bit eat_prev;
  int vld_seen[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_sc[i] = 0; m_st[i] = 0; m_win[i] = 0; m_hi[i] = 0; m_vld[i] = 0;
    end
    eat_prev = 1'b0;
  endfunction

  function automatic void model_clock(bit s, bit e, bit g);
    bit food;
    bit over;
    food = e && !eat_prev;
    for (int i = 0; i < 2; i++) begin
      m_vld[i] = 0;
      if (s) begin
        m_st[i] = 1; m_sc[i] = 0; m_win[i] = 0; m_vld[i] = 1;
      end else if (m_st[i] == 1) begin
        over = g;
        if (food) begin
          m_sc[i]++;
          m_vld[i] = 1;
          if (m_sc[i] == m_max[i]) begin
            m_win[i] = 1;
            over = 1'b1;
          end
        end
        if (over) begin
          m_st[i] = 2;
          if (HI_EN != 0 && m_sc[i] > m_hi[i]) m_hi[i] = m_sc[i];
        end
      end
    end
    eat_prev = e;
  endfunction

  task automatic chk_dut(input string where, input int i,
                         input logic [3:0] ones, input logic [3:0] tens,
                         input logic [3:0] hio, input logic [3:0] hit,
                         input logic vld, input logic [1:0] st, input logic w);
    string p;
    p = $sformatf("%s[%0d]", where, i);
    chk({p, " score_data"}, 32'(ones), 32'(m_sc[i] % 10));
    chk({p, " score_tens"}, 32'(tens), 32'(m_sc[i] / 10));
    chk({p, " hi_ones"},    32'(hio),  32'(m_hi[i] % 10));
    chk({p, " hi_tens"},    32'(hit),  32'(m_hi[i] / 10));
    chk({p, " score_vld"},  32'(vld),  32'(m_vld[i]));
    chk({p, " game_st"},    32'(st),   32'(m_st[i]));
    chk({p, " win"},        32'(w),    32'(m_win[i]));
    if (vld === 1'b1) vld_seen[i]++;
  endtask

  task automatic check_all(input string where);
    chk_dut(where, 0, a_ones, a_tens, a_hio, a_hit, a_vld, a_st, a_win);
    chk_dut(where, 1, b_ones, b_tens, b_hio, b_hit, b_vld, b_st, b_win);
  endtask

  task automatic step(input bit s, input bit e, input bit g);
    start = s; eat = e; game_over = g;
    @(posedge clk);
    model_clock(s, e, g);
    #1;
    check_all("step");
    $display("t=%0t start=%0b eat=%0b go=%0b | a=%0d%0d st=%0d vld=%0b win=%0b hi=%0d%0d | b=%0d%0d st=%0d vld=%0b win=%0b",
             $time, s, e, g, a_tens, a_ones, a_st, a_vld, a_win, a_hit, a_hio,
             b_tens, b_ones, b_st, b_vld, b_win);
    @(negedge clk);
  endtask

  task automatic eat_edge();
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1 model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1 check_all("rst_hold");
    @(negedge clk);
    rst = 1'b0;
    $display("t=%0t async reset pulse", $time);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; eat = 1'b0; game_over = 1'b0;
    model_reset();
    vld_seen = '{0, 0};
    @(negedge clk);
    @(negedge clk);
    check_all("reset");
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    chk("idle_after_reset game_st", 32'(a_st), 32'd0);

    // Twelve foods
    step(1'b1, 1'b0, 1'b0);
    vld_seen = '{0, 0};
    repeat (12) eat_edge();
    chk("r030 score_tens", 32'(a_tens), 32'd1);
    chk("r030 score_data", 32'(a_ones), 32'd2);
    chk("r030 vld pulses", 32'(vld_seen[0]), 32'd12);
    chk("r030 game_st", 32'(a_st), 32'd1);

    // BCD carry 09 -> 10
    step(1'b1, 1'b0, 1'b0);
    repeat (9) eat_edge();
    chk("r031 pre score_data", 32'(a_ones), 32'd9);
    vld_seen = '{0, 0};
    eat_edge();
    chk("r031 score_tens", 32'(a_tens), 32'd1);
    chk("r031 score_data", 32'(a_ones), 32'd0);
    chk("r031 vld pulses", 32'(vld_seen[0]), 32'd1);

    // MAX_SCORE = 15 on instance b
    step(1'b1, 1'b0, 1'b0);
    repeat (15) eat_edge();
    chk("r032 b score_tens", 32'(b_tens), 32'd1);
    chk("r032 b score_data", 32'(b_ones), 32'd5);
    chk("r032 b win", 32'(b_win), 32'd1);
    chk("r032 b game_st", 32'(b_st), 32'd2);
    vld_seen = '{0, 0};
    eat_edge();
    chk("r032 b hold score_data", 32'(b_ones), 32'd5);
    chk("r032 b vld pulses", 32'(vld_seen[1]), 32'd0);
    chk("r032 a vld pulses", 32'(vld_seen[0]), 32'd1);

    // High score across three games
    step(1'b1, 1'b0, 1'b0);
    repeat (7) eat_edge();
    step(1'b0, 1'b0, 1'b1);
    chk("r033 game1 hi_ones", 32'(a_hio), HI_EN != 0 ? 32'd7 : 32'd0);
    step(1'b1, 1'b0, 1'b0);
    repeat (4) eat_edge();
    step(1'b0, 1'b0, 1'b1);
    chk("r033 game2 hi_ones", 32'(a_hio), HI_EN != 0 ? 32'd7 : 32'd0);
    chk("r033 game2 hi_tens", 32'(a_hit), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    repeat (11) eat_edge();
    step(1'b0, 1'b0, 1'b1);
    chk("r033 game3 hi_tens", 32'(a_hit), HI_EN != 0 ? 32'd1 : 32'd0);
    chk("r033 game3 hi_ones", 32'(a_hio), HI_EN != 0 ? 32'd1 : 32'd0);

    // Same-cycle priorities
    step(1'b1, 1'b0, 1'b0);
    repeat (3) eat_edge();
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("r034 eat+go score_data", 32'(a_ones), 32'd4);
    chk("r034 eat+go game_st", 32'(a_st), 32'd2);
    step(1'b1, 1'b0, 1'b1);
    chk("r034 start+go over game_st", 32'(a_st), 32'd1);
    eat_edge();
    step(1'b1, 1'b0, 1'b1);
    chk("r034 start+go play game_st", 32'(a_st), 32'd1);
    chk("r034 start+go play score_data", 32'(a_ones), 32'd0);

    // Mid-game reset, then eat held high through start
    step(1'b1, 1'b0, 1'b0);
    repeat (8) eat_edge();
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    repeat (5) eat_edge();
    chk("r035 pre score_data", 32'(a_ones), 32'd5);
    chk("r035 pre hi_ones", 32'(a_hio), HI_EN != 0 ? 32'd8 : 32'd0);
    async_reset();
    chk("r035 rst score_data", 32'(a_ones), 32'd0);
    chk("r035 rst hi_ones", 32'(a_hio), 32'd0);
    chk("r035 rst game_st", 32'(a_st), 32'd0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    chk("r035 held eat score_data", 32'(a_ones), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("r035 new edge score_data", 32'(a_ones), 32'd1);

    // Random play
    begin
      bit e;
      e = 1'b0;
      for (int n = 0; n < 600; n++) begin
        if ($urandom_range(0, 2) == 0) e = ~e;
        if ($urandom_range(0, 249) == 0) begin
          async_reset();
        end else begin
          step($urandom_range(0, 39) == 0, e, $urandom_range(0, 29) == 0);
        end
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
